// File: rtl/inv_byte_sub_seq.sv
// Sequential AES InvSubBytes stage: optional initial AddRoundKey, then
// BYTES_PER_CYCLE inverse S-box lanes walk the 128-bit state group by group.
module inv_byte_sub_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [3:0]   count_out,
  input  logic [127:0] data_in,
  input  logic [127:0] data_to_store,
  input  logic [127:0] key,
  output logic         ready,
  output logic         done,
  output logic [127:0] data_out
);

  localparam int N = 16 / BYTES_PER_CYCLE;
  localparam logic [3:0] LAST_GROUP = 4'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]   state;
  logic [127:0] work;
  logic [3:0]   group;
  logic [127:0] sub_work;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] t;
    t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  always_comb begin
    sub_work = work;
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      sub_work[8*((int'(group) % N) * BYTES_PER_CYCLE + j) +: 8] =
        inv_sbox(work[8*((int'(group) % N) * BYTES_PER_CYCLE + j) +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      work     <= '0;
      group    <= '0;
      data_out <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            work  <= (count_out == 4'd0) ? (data_in ^ key) : data_to_store;
            group <= '0;
            state <= ST_SUB;
          end
        end
        ST_SUB: begin
          work  <= sub_work;
          group <= group + 4'd1;
          if (group == LAST_GROUP) begin
            data_out <= sub_work;
            done     <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ready = (state == ST_IDLE);

endmodule

// File: tb/tb_inv_byte_sub_seq.sv
// Scoreboard bench for inv_byte_sub_seq: a B=4 main instance checked by a
// monitor process, plus B=1/2/8/16 instances for latency sweeps.
module tb_inv_byte_sub_seq;

  localparam int N_MAIN = 4;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   count_out = '0;
  logic [127:0] data_in = '0;
  logic [127:0] data_to_store = '0;
  logic [127:0] key = '0;
  logic         ready;
  logic         done;
  logic [127:0] data_out;

  logic [3:0]   sw_start = '0;
  logic [3:0]   sw_ready;
  logic [3:0]   sw_done;
  logic [127:0] sw_out [4];

  always #5 clk = ~clk;

  inv_byte_sub_seq #(.BYTES_PER_CYCLE(4)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .count_out(count_out),
    .data_in(data_in), .data_to_store(data_to_store), .key(key),
    .ready(ready), .done(done), .data_out(data_out)
  );

  inv_byte_sub_seq #(.BYTES_PER_CYCLE(1)) u_b1 (
    .clk(clk), .n_rst(n_rst), .start(sw_start[0]), .count_out(count_out),
    .data_in(data_in), .data_to_store(data_to_store), .key(key),
    .ready(sw_ready[0]), .done(sw_done[0]), .data_out(sw_out[0])
  );

  inv_byte_sub_seq #(.BYTES_PER_CYCLE(2)) u_b2 (
    .clk(clk), .n_rst(n_rst), .start(sw_start[1]), .count_out(count_out),
    .data_in(data_in), .data_to_store(data_to_store), .key(key),
    .ready(sw_ready[1]), .done(sw_done[1]), .data_out(sw_out[1])
  );

  inv_byte_sub_seq #(.BYTES_PER_CYCLE(8)) u_b8 (
    .clk(clk), .n_rst(n_rst), .start(sw_start[2]), .count_out(count_out),
    .data_in(data_in), .data_to_store(data_to_store), .key(key),
    .ready(sw_ready[2]), .done(sw_done[2]), .data_out(sw_out[2])
  );

  inv_byte_sub_seq #(.BYTES_PER_CYCLE(16)) u_b16 (
    .clk(clk), .n_rst(n_rst), .start(sw_start[3]), .count_out(count_out),
    .data_in(data_in), .data_to_store(data_to_store), .key(key),
    .ready(sw_ready[3]), .done(sw_done[3]), .data_out(sw_out[3])
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  int acc_last = -100;
  logic [127:0] exp_q [$];
  logic [7:0] inv_tab [256];

  // Reference field arithmetic: carry-less product, then reduce by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // Forward S-box from its definition, inverted by table placement.
  task automatic build_table();
    logic [7:0] y;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      y = 8'h00;
      for (int c = 1; c < 256; c++)
        if (x != 0 && ref_gmul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
      s = y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [3:0] c, input logic [127:0] din,
                                         input logic [127:0] dts, input logic [127:0] k);
    logic [127:0] st;
    logic [127:0] r;
    st = (c == 4'd0) ? (din ^ k) : dts;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[st[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic randomize_inputs();
    count_out     = 4'($urandom);
    data_in       = rnd128();
    data_to_store = rnd128();
    key           = rnd128();
  endtask

  // Monitor: checks handshake timing every cycle and pops the scoreboard on done.
  initial begin
    logic [127:0] last_out;
    logic [127:0] e;
    last_out = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!n_rst) begin
        check("reset_data_out", data_out, '0);
        check("reset_done", 128'(done), 128'(0));
        check("reset_ready", 128'(ready), 128'(1));
        exp_q.delete();
        acc_last = -100;
        last_out = '0;
      end else begin
        check("ready", 128'(ready), 128'((cyc < acc_last) || (cyc > acc_last + N_MAIN)));
        check("done", 128'(done), 128'(cyc == acc_last + N_MAIN));
        if (done) begin
          if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("[TB] FAIL unexpected_done: got done=1 expected no pending block");
          end else begin
            e = exp_q.pop_front();
            check("data_out", data_out, e);
            last_out = e;
          end
        end else begin
          check("hold", data_out, last_out);
        end
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      chk_cnt++;
      $display("[TB] FAIL ready_timeout: got ready=%0b expected 1", ready);
    end
  endtask

  task automatic send(input logic [3:0] c, input logic [127:0] din,
                      input logic [127:0] dts, input logic [127:0] k);
    wait_idle();
    count_out = c; data_in = din; data_to_store = dts; key = k;
    start = 1'b1;
    exp_q.push_back(model(c, din, dts, k));
    acc_last = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    randomize_inputs();
  endtask

  // start held high with inputs churning; acceptances every N+2 edges.
  task automatic stream(input int nblk);
    wait_idle();
    for (int j = 0; j < nblk * (N_MAIN + 2); j++) begin
      if (j > 0) @(negedge clk);
      randomize_inputs();
      if ($urandom_range(0, 1) == 0) count_out = 4'd0;
      start = 1'b1;
      if (j % (N_MAIN + 2) == 0) begin
        exp_q.push_back(model(count_out, data_in, data_to_store, key));
        acc_last = cyc + 1;
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sweep(input int idx, input int n, input logic [3:0] c,
                       input logic [127:0] din, input logic [127:0] dts, input logic [127:0] k);
    int t;
    logic [127:0] e;
    @(negedge clk);
    check("sweep_ready", 128'(sw_ready[idx]), 128'(1));
    count_out = c; data_in = din; data_to_store = dts; key = k;
    e = model(c, din, dts, k);
    sw_start[idx] = 1'b1;
    @(negedge clk);
    sw_start[idx] = 1'b0;
    randomize_inputs();
    t = 0;
    while (!sw_done[idx] && t < 40) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("sweep_latency_b%0d", 16 / n), 128'(t), 128'(n));
    check($sformatf("sweep_data_b%0d", 16 / n), sw_out[idx], e);
    @(negedge clk);
    check("sweep_done_fall", 128'(sw_done[idx]), 128'(0));
    check("sweep_ready_back", 128'(sw_ready[idx]), 128'(1));
  endtask

  localparam logic [127:0] PAT_IN  = {{14{8'h16}}, 8'h7C, 8'h63};
  localparam logic [127:0] PAT_OUT = {{14{8'hFF}}, 8'h01, 8'h00};

  initial begin
    logic [127:0] blk;
    int t;
    build_table();
    randomize_inputs();
    start = 1'($urandom);
    @(negedge clk);
    randomize_inputs();
    start = 1'($urandom);
    @(negedge clk);
    n_rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_data_out", data_out, '0);
    check("idle_ready", 128'(ready), 128'(1));
    check("idle_done", 128'(done), 128'(0));

    send(4'd0, '0, rnd128(), '0);
    send(4'd0, {16{8'h63}}, rnd128(), '0);
    send(4'd0, '0, rnd128(), {16{8'h63}});
    send(4'd5, rnd128(), PAT_IN, rnd128());
    wait_idle();
    check("pattern_out", data_out, PAT_OUT);

    for (int j = 0; j < 256; j++) begin
      for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'(j + i);
      send(4'($urandom_range(1, 15)), rnd128(), blk, rnd128());
    end
    for (int j = 0; j < 20; j++)
      send(($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
           rnd128(), rnd128(), rnd128());

    stream(6);

    wait_idle();
    count_out = 4'd0; data_in = rnd128(); key = rnd128();
    start = 1'b1;
    acc_last = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    check("midreset_data_out", data_out, '0);
    check("midreset_ready", 128'(ready), 128'(1));
    send(4'd3, rnd128(), rnd128(), rnd128());

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      chk_cnt++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end

    sweep(0, 16, 4'd0, '0, rnd128(), '0);
    sweep(0, 16, 4'd5, rnd128(), PAT_IN, rnd128());
    sweep(1, 8, 4'd0, '0, rnd128(), '0);
    sweep(1, 8, 4'd5, rnd128(), PAT_IN, rnd128());
    sweep(2, 2, 4'd0, '0, rnd128(), '0);
    sweep(2, 2, 4'd5, rnd128(), PAT_IN, rnd128());
    sweep(3, 1, 4'd0, '0, rnd128(), '0);
    sweep(3, 1, 4'd5, rnd128(), PAT_IN, rnd128());
    sweep(3, 1, 4'd0, rnd128(), rnd128(), rnd128());

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/inv_byte_sub_seq.md
Name: inv_byte_sub_seq

Overview:
- Sequential InvSubBytes stage for the AES decryption datapath; the decrypt-side counterpart of the forward byte-substitution stage.
- On the round-0 pass it first XORs the incoming block with the supplied round key (initial AddRoundKey).
- Substitutes the 128-bit state through the AES inverse S-box, BYTES_PER_CYCLE bytes per clock, using a start/ready/done handshake.
- Sits between the inverse-shift-rows result register and the inverse-mix-columns/key-add stage in the decrypt round loop.

Parameters:
- BYTES_PER_CYCLE, 4, number of inverse S-box lanes instantiated; legal values 1, 2, 4, 8, 16; N = 16/BYTES_PER_CYCLE is the processing cycle count.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  synchronous active-low reset.
- start  input  1  request to process one block; sampled only when ready=1.
- count_out  input  4  round counter from the round controller; 0 selects the key-add path.
- data_in  input  128  ciphertext/state block used when count_out=0.
- data_to_store  input  128  intermediate state used when count_out!=0.
- key  input  128  round key XORed in when count_out=0.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse when data_out holds a new result.
- data_out  output  128  substituted block; registered.

Behaviour:
- Reset (n_rst=0 at a rising edge): state=IDLE, working register=0, group index=0, data_out=0, done=0, ready=1. Reset wins over every other input, including mid-operation; a partial result is discarded and data_out returns to 0.
- States: IDLE, SUB, DONE.
- IDLE:
  - If start=1 at an edge, the working register captures (data_in ^ key) when count_out=0, otherwise data_to_store.
  - The group index clears to 0 and the state moves to SUB.
  - count_out, data_in, data_to_store and key are sampled only at this edge; later changes are ignored.
- SUB:
  - Each edge replaces byte lanes [g*B .. g*B+B-1] of the working register with InvSbox(byte), where B=BYTES_PER_CYCLE and g is the group index.
  - Byte lane i is bits [8i+7:8i], so lane 0 is the LSB.
  - The group index increments on each edge. On the edge that processes group N-1, the fully substituted value is loaded into data_out, done is set, and the state moves to DONE.
- DONE: done=1 for exactly this one cycle. The next edge clears done and returns the state to IDLE unconditionally.
- start is ignored in SUB and DONE (ready=0); no queuing. Back-to-back throughput is one block per N+2 cycles.
- Latency: with start accepted at edge k, data_out and done update at edge k+N, done falls at edge k+N+1, and ready=1 again from edge k+N+1.
- data_out holds its last value between completions and does not change during SUB.
- The inverse S-box is the FIPS-197 inverse table, implemented as a combinational lookup per lane and exhaustively correct for all 256 inputs.
- N=1 (B=16): SUB lasts one edge, and the whole block completes at edge k+1.

Test Plan:
1. Reset value: hold n_rst=0 for 2 edges with random inputs -> data_out=0, done=0, ready=1; release reset and leave start=0 -> outputs unchanged.
2. Key path: count_out=0, data_in=0x00..00, key=0x00..00, start pulse -> after 4 edges (B=4) data_out=0x5252..52, done high exactly one cycle, ready=0 for 5 cycles.
3. Key cancellation: count_out=0, data_in=0x6363..63, key=0x0000..00 -> data_out=0x00..00. Then data_in=0x00..00, key=0x6363..63 -> 0x00..00.
4. Stored path and lane order:
   - count_out=5, data_to_store=0x16..16 7C 63 (top 14 bytes 0x16) -> data_out=0xFF..FF 01 00.
   - Exhaustive sweep of all 256 byte values, placed in each lane in turn, against a software inverse S-box.
5. Handshake: assert start continuously while ready=0, and toggle data_to_store and count_out mid-operation -> result reflects only the values sampled at acceptance; the next block is accepted at the first edge after done falls.
6. Mid-operation reset and parameter sweep:
   - Assert n_rst=0 at the second SUB edge -> data_out=0, state IDLE; a new block then completes normally.
   - Repeat scenarios 2 and 4 with BYTES_PER_CYCLE=1, 2, 8 and 16 -> latencies 16, 8, 2 and 1 cycles.
